// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: issues aligned word requests with byte strobes,
// stalls the core while outstanding, extends load data for writeback.
module lsu_mem_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, state_nx;
    logic        st_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [7:0]  cnt;
    logic        fault_q;
    logic        legal, aligned;
    logic        accept, complete, expire;
    logic        stall_c, fault_c;
    logic [3:0]  strb_c;
    logic [31:0] wdata_c;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext_c;

    // Decode funct3 legality and natural alignment of the request
    always_comb begin
        legal   = 1'b0;
        aligned = 1'b1;
        case (funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !is_store;
            default:                legal = 1'b0;
        endcase
        case (funct3[1:0])
            2'b01:   aligned = !addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    // Next-state and handshake control
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        complete = 1'b0;
        expire   = 1'b0;
        stall_c  = 1'b0;
        fault_c  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (legal && aligned) begin
                        accept   = 1'b1;
                        stall_c  = 1'b1;
                        state_nx = WAIT;
                    end else begin
                        fault_c = 1'b1;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (mem_ready) begin
                    complete = 1'b1;
                    state_nx = DONE;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    expire   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign stall = stall_c & rst_n;
    assign fault = fault_q | (fault_c & rst_n);

    // Store strobes and lane-replicated store data
    always_comb begin
        strb_c  = 4'b0000;
        wdata_c = wdata;
        case (funct3[1:0])
            2'b00: begin
                strb_c  = 4'b0001 << addr[1:0];
                wdata_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                strb_c  = 4'b0011 << {addr[1], 1'b0};
                wdata_c = {2{wdata[15:0]}};
            end
            default: begin
                strb_c  = 4'b1111;
                wdata_c = wdata;
            end
        endcase
        if (!is_store) strb_c = 4'b0000;
    end

    // Lane select and sign/zero extension of returned read data
    always_comb begin
        lane_b = mem_rdata[8*off_q +: 8];
        lane_h = mem_rdata[16*off_q[1] +: 16];
        case (f3_q)
            3'b000:  ext_c = {{24{lane_b[7]}}, lane_b};
            3'b001:  ext_c = {{16{lane_h[15]}}, lane_h};
            3'b100:  ext_c = {24'h0, lane_b};
            3'b101:  ext_c = {16'h0, lane_h};
            default: ext_c = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Request registers, wait counter and load result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wstrb  <= 4'h0;
            mem_wdata  <= 32'h0;
            load_data  <= 32'h0;
            load_valid <= 1'b0;
            fault_q    <= 1'b0;
            cnt        <= 8'h0;
            st_q       <= 1'b0;
            f3_q       <= 3'b0;
            off_q      <= 2'b0;
        end else begin
            load_valid <= complete && !st_q;
            fault_q    <= expire;
            if (accept) begin
                mem_req   <= 1'b1;
                mem_we    <= is_store;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_wstrb <= strb_c;
                mem_wdata <= wdata_c;
                st_q      <= is_store;
                f3_q      <= funct3;
                off_q     <= addr[1:0];
                cnt       <= 8'h0;
            end else if (complete || expire) begin
                mem_req <= 1'b0;
            end else if (state == WAIT) begin
                cnt <= cnt + 8'h1;
            end
            if (complete && !st_q) load_data <= ext_c;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: vector table of single accesses
// plus hand sequences for timeout and reset during WAIT.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int nchk  = 0;
    int nfail = 0;
    logic [31:0] last_ld = 32'h0;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          lat;
        logic        bad;
        logic [3:0]  strb;
        logic [31:0] mwd;
        logic [31:0] ld;
    } vec_t;

    vec_t v[14];

    lsu_mem_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .is_store(is_store),
        .funct3(funct3),
        .addr(addr),
        .wdata(wdata),
        .stall(stall),
        .load_data(load_data),
        .load_valid(load_valid),
        .fault(fault),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t t);
        int stalls;
        stalls    = 0;
        is_store  = t.st;
        funct3    = t.f3;
        addr      = t.a;
        wdata     = t.wd;
        req_valid = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("req_fault", 32'(fault), 32'(t.bad));
        chk("req_stall", 32'(stall), 32'(!t.bad));
        if (stall) stalls++;
        step();
        if (t.bad) begin
            req_valid = 1'b0;
            @(negedge clk);
            chk("bad_mem_req", 32'(mem_req), 32'h0);
            chk("bad_stall", 32'(stall), 32'h0);
            chk("bad_fault_pulse", 32'(fault), 32'h0);
            chk("bad_load_data", load_data, last_ld);
            step();
            return;
        end
        for (int i = 1; i <= t.lat; i++) begin
            mem_ready = (i == t.lat);
            mem_rdata = (i == t.lat) ? t.rd : 32'h0;
            @(negedge clk);
            chk("wait_mem_req", 32'(mem_req), 32'h1);
            chk("wait_stall", 32'(stall), 32'h1);
            chk("wait_mem_addr", mem_addr, {t.a[31:2], 2'b00});
            chk("wait_mem_we", 32'(mem_we), 32'(t.st));
            chk("wait_mem_wstrb", 32'(mem_wstrb), 32'(t.strb));
            if (t.st) chk("wait_mem_wdata", mem_wdata, t.mwd);
            chk("wait_load_valid", 32'(load_valid), 32'h0);
            if (stall) stalls++;
            step();
        end
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        @(negedge clk);
        chk("done_stall", 32'(stall), 32'h0);
        chk("done_mem_req", 32'(mem_req), 32'h0);
        chk("done_fault", 32'(fault), 32'h0);
        chk("done_load_valid", 32'(load_valid), 32'(!t.st));
        if (!t.st) last_ld = t.ld;
        chk("done_load_data", load_data, last_ld);
        chk("stall_cycles", 32'(stalls), 32'(t.lat + 1));
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        // st f3 addr wdata rdata lat bad strb mwdata load
        v[0]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1'b0,
                  4'b0000, 32'h0, 32'hDEADBEEF};
        v[1]  = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 2, 1'b0,
                  4'b0000, 32'h0, 32'hFFFFFF80};
        v[2]  = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF7F01, 1, 1'b0,
                  4'b0000, 32'h0, 32'h00000080};
        v[3]  = '{1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3, 1'b0,
                  4'b1100, 32'hABCDABCD, 32'h0};
        v[4]  = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF7F01, 1, 1'b0,
                  4'b0000, 32'h0, 32'hFFFF80FF};
        v[5]  = '{1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF7F01, 2, 1'b0,
                  4'b0000, 32'h0, 32'h00007F01};
        v[6]  = '{1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 1, 1'b0,
                  4'b0010, 32'hA5A5A5A5, 32'h0};
        v[7]  = '{1'b1, 3'b010, 32'h304, 32'hCAFEF00D, 32'h0, 2, 1'b0,
                  4'b1111, 32'hCAFEF00D, 32'h0};
        v[8]  = '{1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1, 1'b1,
                  4'b0000, 32'h0, 32'h0};
        v[9]  = '{1'b1, 3'b011, 32'h300, 32'h0, 32'h0, 1, 1'b1,
                  4'b0000, 32'h0, 32'h0};
        v[10] = '{1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 1, 1'b1,
                  4'b0000, 32'h0, 32'h0};
        v[11] = '{1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1, 1'b1,
                  4'b0000, 32'h0, 32'h0};
        v[12] = '{1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1, 1'b1,
                  4'b0000, 32'h0, 32'h0};
        v[13] = '{1'b0, 3'b000, 32'h100, 32'h0, 32'h80FF7F01, 1, 1'b0,
                  4'b0000, 32'h0, 32'h00000001};

        rst_n     = 1'b0;
        req_valid = 1'b1;
        is_store  = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h100;
        wdata     = 32'h0;
        mem_rdata = 32'h0;
        mem_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_load_valid", 32'(load_valid), 32'h0);
        step();
        rst_n     = 1'b1;
        req_valid = 1'b0;

        for (int k = 0; k < 14; k++) run(v[k]);

        // Timeout: four WAIT cycles with no ready, then fault in DONE
        is_store  = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h400;
        req_valid = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("to_req_stall", 32'(stall), 32'h1);
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_wait_mem_req", 32'(mem_req), 32'h1);
            chk("to_wait_fault", 32'(fault), 32'h0);
            step();
        end
        @(negedge clk);
        chk("to_done_fault", 32'(fault), 32'h1);
        chk("to_done_load_valid", 32'(load_valid), 32'h0);
        chk("to_done_stall", 32'(stall), 32'h0);
        chk("to_done_mem_req", 32'(mem_req), 32'h0);
        chk("to_done_load_data", load_data, last_ld);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("to_fault_pulse", 32'(fault), 32'h0);
        step();

        // Ready on the last allowed WAIT cycle completes normally
        run('{1'b0, 3'b010, 32'h404, 32'h0, 32'h12345678, 4, 1'b0,
              4'b0000, 32'h0, 32'h12345678});

        // Reset while in WAIT, then a stray ready
        is_store  = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h500;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("rw_mem_req", 32'(mem_req), 32'h1);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rw_stall_in_rst", 32'(stall), 32'h0);
        step();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        chk("rw_mem_req_drop", 32'(mem_req), 32'h0);
        chk("rw_load_data", load_data, 32'h0);
        chk("rw_mem_addr", mem_addr, 32'h0);
        chk("rw_stall", 32'(stall), 32'h0);
        step();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        @(negedge clk);
        chk("rw_no_load_valid", 32'(load_valid), 32'h0);
        chk("rw_no_fault", 32'(fault), 32'h0);
        step();
        last_ld = 32'h0;
        run('{1'b0, 3'b010, 32'h600, 32'h0, 32'h0BADF00D, 2, 1'b0,
              4'b0000, 32'h0, 32'h0BADF00D});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
